// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands MSB-first, SLICE bits
// per cycle, stopping at the first differing slice. Valid/ready on both sides.
module seq_magnitude_comparator #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    localparam int NSLICE = WIDTH / SLICE,
    localparam int CW = $clog2(NSLICE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [CW-1:0]    slices
);

    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] msb_flip;
    logic [IW-1:0]    idx;
    logic [SLICE-1:0] a_slice, b_slice;
    logic             accept, consume, last_slice;

    // Offset binary: flipping both MSBs turns signed ordering into unsigned ordering.
    assign msb_flip   = WIDTH'(signed_mode) << (WIDTH - 1);
    assign accept     = (state == IDLE) && in_valid;
    assign consume    = (state == DONE) && out_ready;
    assign a_slice    = a_q[idx*SLICE +: SLICE];
    assign b_slice    = b_q[idx*SLICE +: SLICE];
    assign last_slice = (idx == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, otherwise a missed
    // branch infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CMP;
            CMP:     if (a_slice != b_slice || last_slice) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // NOTE: operand and index registers are reset too; they are few and cheap, and
    // reset leaves nothing stale to leak into the next transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            idx    <= '0;
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
            slices <= '0;
        end else if (accept) begin
            a_q    <= a ^ msb_flip;
            b_q    <= b ^ msb_flip;
            idx    <= IW'(NSLICE - 1);
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
            slices <= '0;
        end else if (state == CMP) begin
            slices <= slices + CW'(1);
            if (a_slice > b_slice)      gt  <= 1'b1;
            else if (a_slice < b_slice) lt  <= 1'b1;
            else if (last_slice)        eq  <= 1'b1;
            else                        idx <= idx - IW'(1);
        end else if (consume) begin
            // Result flags must read zero again once back in IDLE.
            eq     <= 1'b0;
            gt     <= 1'b0;
            lt     <= 1'b0;
            slices <= '0;
        end
    end

endmodule
